mem_responder: RTL

- Serial memory-side endpoint for the CPU's NSHIFT-bit TX/RX link.
- Decodes TX messages (start, command, payload) arriving on tx_pins and executes them against an internal byte RAM.
- Returns read data as RX messages on rx_pins.
- Used as the memory model in system simulation, and as the reference responder when verifying the CPU scheduler's TX/RX sequencing.

---
 rtl/mem_responder.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/mem_responder.sv
// Serial memory-side endpoint for the NSHIFT-bit TX/RX link.
// Executes TX read/write messages against a byte RAM and replies on RX.
module mem_responder #(
  parameter int NSHIFT         = 2,
  parameter int PAYLOAD_CYCLES = 8,
  parameter int ADDR_BITS      = 8,
  parameter int REPLY_DELAY    = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NSHIFT-1:0]    tx_pins,
  output logic [NSHIFT-1:0]    rx_pins,
  output logic                 tx_busy,
  output logic                 rx_busy,
  output logic                 overflow,
  input  logic                 bd_we,
  input  logic [ADDR_BITS-1:0] bd_addr,
  input  logic [7:0]           bd_wdata,
  output logic [7:0]           bd_rdata
);

  localparam int PW    = NSHIFT * PAYLOAD_CYCLES;
  localparam int DEPTH = 1 << ADDR_BITS;
  localparam int CW    = $clog2(PAYLOAD_CYCLES);
  localparam int RMAX  = (PAYLOAD_CYCLES > 16) ? PAYLOAD_CYCLES : 16;
  localparam int RW    = $clog2(RMAX);

  localparam logic [NSHIFT-1:0] START = NSHIFT'(1);
  localparam logic [NSHIFT-1:0] RD16  = NSHIFT'(0);
  localparam logic [NSHIFT-1:0] WR8   = NSHIFT'(1);
  localparam logic [NSHIFT-1:0] WR16  = NSHIFT'(2);

  typedef enum logic [1:0] {
    TX_IDLE, TX_CMD, TX_PAY
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_WAIT, RX_START, RX_DATA
  } rx_state_t;

  logic [7:0] mem [DEPTH];

  tx_state_t             tx_q, tx_n;
  logic [CW-1:0]         tx_cnt;
  logic [NSHIFT-1:0]     cmd_q;
  logic [PW-NSHIFT-1:0]  pl_sr;
  logic [PW-1:0]         pl_word;
  logic                  tx_done;
  logic                  rd_done, rd_accept;
  logic                  wr8, wr16;

  logic [ADDR_BITS-1:0]  addr_latch;
  logic [ADDR_BITS-1:0]  a_rd, a_rd1, a_wr1;
  logic [PW-1:0]         snap;

  rx_state_t             rx_q, rx_n;
  logic [RW-1:0]         rx_cnt, rx_cnt_n;
  logic [NSHIFT-1:0]     rx_pins_d;

  // TX state register
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_q   <= TX_IDLE;
      tx_cnt <= '0;
    end else begin
      tx_q <= tx_n;
      if (tx_q == TX_CMD)
        tx_cnt <= '0;
      else if (tx_q == TX_PAY)
        tx_cnt <= tx_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (tx_q == TX_CMD)
      cmd_q <= tx_pins;
    if (tx_q == TX_PAY)
      pl_sr <= pl_word[PW-1:NSHIFT];
  end

  // TX next state
  always_comb begin
    tx_n = tx_q;
    unique case (tx_q)
      TX_IDLE: if (tx_pins == START) tx_n = TX_CMD;
      TX_CMD:  tx_n = TX_PAY;
      TX_PAY:  if (tx_done) tx_n = TX_IDLE;
      default: tx_n = TX_IDLE;
    endcase
  end

  // TX outputs; the last payload pair is merged straight from the pins
  always_comb begin
    tx_busy = (tx_q != TX_IDLE);
    pl_word = {tx_pins, pl_sr};
    tx_done = (tx_q == TX_PAY) && !reset &&
              (tx_cnt == CW'(PAYLOAD_CYCLES - 1));
    rd_done = tx_done && (cmd_q == RD16);
    wr8     = tx_done && (cmd_q == WR8);
    wr16    = tx_done && (cmd_q == WR16);
  end

  assign rd_accept = rd_done && (rx_q == RX_IDLE);
  assign a_rd      = pl_word[ADDR_BITS-1:0];
  assign a_rd1     = a_rd + ADDR_BITS'(1);
  assign a_wr1     = addr_latch + ADDR_BITS'(1);
  assign bd_rdata  = mem[bd_addr];

  // Link writes come after the backdoor so they win a same-byte clash
  always_ff @(posedge clk) begin
    if (bd_we)
      mem[bd_addr] <= bd_wdata;
    if (wr8 || wr16)
      mem[addr_latch] <= pl_word[7:0];
    if (wr16)
      mem[a_wr1] <= pl_word[15:8];
  end

  always_ff @(posedge clk) begin
    if (rd_accept)
      snap <= {mem[a_rd1], mem[a_rd]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_latch <= '0;
      overflow   <= 1'b0;
    end else begin
      if (rd_done)
        addr_latch <= a_rd;
      if (rd_done && (rx_q != RX_IDLE))
        overflow <= 1'b1;
    end
  end

  // RX state register
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q    <= RX_IDLE;
      rx_cnt  <= '0;
      rx_pins <= '0;
    end else begin
      rx_q    <= rx_n;
      rx_cnt  <= rx_cnt_n;
      rx_pins <= rx_pins_d;
    end
  end

  // RX next state
  always_comb begin
    rx_n     = rx_q;
    rx_cnt_n = rx_cnt;
    unique case (rx_q)
      RX_IDLE: begin
        if (rd_accept) begin
          rx_n     = (REPLY_DELAY == 0) ? RX_START : RX_WAIT;
          rx_cnt_n = '0;
        end
      end
      RX_WAIT: begin
        if (rx_cnt == RW'(REPLY_DELAY - 1)) begin
          rx_n     = RX_START;
          rx_cnt_n = '0;
        end else begin
          rx_cnt_n = rx_cnt + RW'(1);
        end
      end
      RX_START: begin
        rx_n     = RX_DATA;
        rx_cnt_n = '0;
      end
      RX_DATA: begin
        if (rx_cnt == RW'(PAYLOAD_CYCLES - 1)) begin
          rx_n     = RX_IDLE;
          rx_cnt_n = '0;
        end else begin
          rx_cnt_n = rx_cnt + RW'(1);
        end
      end
      default: begin
        rx_n     = RX_IDLE;
        rx_cnt_n = '0;
      end
    endcase
  end

  // RX outputs; pins are decoded from the next state and registered
  always_comb begin
    rx_busy   = (rx_q != RX_IDLE);
    rx_pins_d = '0;
    unique case (1'b1)
      (rx_n == RX_START): rx_pins_d = START;
      (rx_n == RX_DATA):  rx_pins_d = snap[NSHIFT*rx_cnt_n +: NSHIFT];
      default:            rx_pins_d = '0;
    endcase
  end

endmodule
